// File: rtl/fp_sp_pkg.sv
// fp_sp_pkg: shared class encoding, flag positions and IEEE-754 single constants
// for the multiplier normalise/round back end.
package fp_sp_pkg;

  // Operand class codes are mutually exclusive values rather than independent
  // bits: a special signed zero needs a code of its own, separate from the
  // ordinary "use the product" case.
  typedef enum logic [2:0] {
    CLS_NORMAL     = 3'd0,
    CLS_ZERO       = 3'd1,
    CLS_INF        = 3'd2,
    CLS_INF_X_ZERO = 3'd3,
    CLS_NAN        = 3'd4
  } fp_cls_e;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}.
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] INF      = 32'h7F80_0000;

  // One packed result word as it travels through the register stages.
  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  flags;
  } fp_res_t;

endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational round-to-nearest-even of a 23-bit fraction.
// A carry-out leaves o_mant at zero; the caller bumps the exponent.
module fp_rne_round (
  input  logic [22:0] i_mant,
  input  logic        i_guard,
  input  logic        i_sticky,
  output logic [22:0] o_mant,
  output logic        o_carry,
  output logic        o_inexact
);

  logic w_inc;

  assign w_inc                = i_guard & (i_sticky | i_mant[0]);
  assign {o_carry, o_mant}    = {1'b0, i_mant} + {23'd0, w_inc};
  assign o_inexact            = i_guard | i_sticky;

endmodule

// File: rtl/sp_mult_norm_rnd.sv
// sp_mult_norm_rnd: normalise, round-to-nearest-even and pack a 24x24 mantissa
// product into an IEEE-754 single result behind a valid/ready handshake.
// Optional macro FP_MULT_OUT_REG_EN adds a second handshaked output register
// (latency 2); without it the result is registered once (latency 1).
module sp_mult_norm_rnd
  import fp_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_prod,
  input  logic [9:0]  in_exp,
  input  logic        in_sign,
  input  logic [2:0]  in_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [3:0]  out_flags
);

  localparam logic signed [10:0] ExpMaxS = 11'(EXP_MAX);

  logic               w_prod_hi;
  logic [22:0]        w_mant_pre;
  logic               w_guard;
  logic               w_sticky;
  logic [22:0]        w_mant_rnd;
  logic               w_carry;
  logic               w_inexact;
  logic signed [10:0] w_exp_fin;
  fp_res_t            w_res;
  logic               w_s1_dn_ready;

  logic               r_s1_valid;
  fp_res_t            r_s1;

  // A product in [2,4) has its leading one at bit 47 and takes one extra
  // exponent step; otherwise the leading one sits at bit 46.
  assign w_prod_hi  = in_prod[47];
  assign w_mant_pre = w_prod_hi ? in_prod[46:24] : in_prod[45:23];
  assign w_guard    = w_prod_hi ? in_prod[23]    : in_prod[22];
  assign w_sticky   = w_prod_hi ? (|in_prod[22:0]) : (|in_prod[21:0]);

  fp_rne_round u_round (
    .i_mant    (w_mant_pre),
    .i_guard   (w_guard),
    .i_sticky  (w_sticky),
    .o_mant    (w_mant_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  // 11-bit signed sum so any 10-bit input exponent plus two increments cannot wrap.
  assign w_exp_fin = $signed({in_exp[9], in_exp})
                   + $signed({10'd0, w_prod_hi})
                   + $signed({10'd0, w_carry});

  // Pick the packed result: special classes first, then overflow/underflow, else the rounded number.
  always_comb begin
    w_res.z                   = {in_sign, w_exp_fin[7:0], w_mant_rnd};
    w_res.flags               = '0;
    w_res.flags[FLAG_INEXACT] = w_inexact;
    case (in_cls)
      CLS_NAN: begin
        w_res.z     = QNAN;
        w_res.flags = '0;
      end
      CLS_INF_X_ZERO: begin
        w_res.z                   = QNAN;
        w_res.flags               = '0;
        w_res.flags[FLAG_INVALID] = 1'b1;
      end
      CLS_INF: begin
        w_res.z     = INF | {in_sign, 31'd0};
        w_res.flags = '0;
      end
      CLS_ZERO: begin
        w_res.z     = {in_sign, 31'd0};
        w_res.flags = '0;
      end
      default: begin
        if (w_exp_fin >= ExpMaxS) begin
          w_res.z                    = INF | {in_sign, 31'd0};
          w_res.flags                = '0;
          w_res.flags[FLAG_OVERFLOW] = 1'b1;
          w_res.flags[FLAG_INEXACT]  = 1'b1;
        end else if (w_exp_fin <= 11'sd0) begin
          w_res.z                     = {in_sign, 31'd0};
          w_res.flags                 = '0;
          w_res.flags[FLAG_UNDERFLOW] = 1'b1;
          w_res.flags[FLAG_INEXACT]   = 1'b1;
        end
      end
    endcase
  end

  // Stage 1 can take a new word when empty or when its current word leaves this edge.
  assign in_ready = !r_s1_valid || w_s1_dn_ready;

  // Stage 1 register: load on accept, drain to empty when nothing new arrives, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_res;
      end
    end
  end

`ifdef FP_MULT_OUT_REG_EN
  logic    w_s2_ready;
  logic    r_s2_valid;
  fp_res_t r_s2;

  assign w_s2_ready    = !r_s2_valid || out_ready;
  assign w_s1_dn_ready = w_s2_ready;

  // Stage 2 register: same accept/drain/hold rule, fed from stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2 <= r_s1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_z     = r_s2.z;
  assign out_flags = r_s2.flags;
`else
  assign w_s1_dn_ready = out_ready;
  assign out_valid     = r_s1_valid;
  assign out_z         = r_s1.z;
  assign out_flags     = r_s1.flags;
`endif

endmodule

// File: tb/tb_sp_mult_norm_rnd.sv
// tb_sp_mult_norm_rnd: directed bench for sp_mult_norm_rnd with a queue-based
// reference model; honours FP_MULT_OUT_REG_EN for the expected latency.
module tb_sp_mult_norm_rnd;
  import fp_sp_pkg::*;

`ifdef FP_MULT_OUT_REG_EN
  localparam int Latency = 2;
`else
  localparam int Latency = 1;
`endif

  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  f;
  } res_t;

  typedef struct packed {
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    logic [2:0]  c;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_prod = '0;
  logic [9:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic [2:0]  in_cls = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_z;
  logic [3:0]  out_flags;

  int compared = 0;
  int mismatched = 0;
  int acceptCount = 0;
  int deliverCount = 0;

  res_t  expQ[$];
  stim_t streamTab[4];

  logic        prevStall = 1'b0;
  logic [31:0] prevZ = '0;
  logic [3:0]  prevF = '0;

  always #5 clk = ~clk;

  sp_mult_norm_rnd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .in_cls    (in_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_flags (out_flags)
  );

  // Reference: treat the product as an integer significand, shift out the
  // fraction, round by comparing the remainder with one half, then re-bias.
  function automatic res_t modelMul(input logic [47:0] p, input logic [9:0] e,
                                    input logic s, input logic [2:0] c);
    res_t            r;
    longint unsigned full, sig, rem, half;
    int              sh, unb, biased;
    logic            inexact;
    r.z = 32'd0;
    r.f = 4'd0;
    if (c == CLS_NAN) begin
      r.z = 32'h7FC0_0000;
      return r;
    end
    if (c == CLS_INF_X_ZERO) begin
      r.z = 32'h7FC0_0000;
      r.f = 4'b1000;
      return r;
    end
    if (c == CLS_INF) begin
      r.z = {s, 31'h7F80_0000};
      return r;
    end
    if (c == CLS_ZERO) begin
      r.z = {s, 31'd0};
      return r;
    end
    full    = 64'(p);
    sh      = p[47] ? 24 : 23;
    sig     = full >> sh;
    rem     = full & ((64'd1 << sh) - 64'd1);
    half    = 64'd1 << (sh - 1);
    inexact = (rem != 64'd0);
    if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    unb = int'($signed(e)) - EXP_BIAS + (sh - 23);
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      unb = unb + 1;
    end
    biased = unb + EXP_BIAS;
    if (biased >= EXP_MAX) begin
      r.z = {s, 31'h7F80_0000};
      r.f = 4'b0101;
    end else if (biased <= 0) begin
      r.z = {s, 31'd0};
      r.f = 4'b0011;
    end else begin
      r.z = {s, biased[7:0], sig[22:0]};
      r.f = {3'b000, inexact};
    end
    return r;
  endfunction

  // Scoreboard: push the model result on every accept, compare on every
  // delivery, and require stable outputs while the output is stalled.
  always @(negedge clk) begin
    res_t ex;
    if (!rst_n) begin
      expQ.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        compared++;
        if (out_valid !== 1'b1 || out_z !== prevZ || out_flags !== prevF) begin
          mismatched++;
          $display("[TB] FAIL hold_stable: got v=%b z=%h f=%b, want v=1 z=%h f=%b",
                   out_valid, out_z, out_flags, prevZ, prevF);
        end
      end
      if (out_valid && out_ready) begin
        deliverCount++;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_output: got z=%h f=%b, want no output", out_z, out_flags);
        end else begin
          ex = expQ.pop_front();
          if (out_z !== ex.z || out_flags !== ex.f) begin
            mismatched++;
            $display("[TB] FAIL model_compare: got z=%h f=%b, want z=%h f=%b",
                     out_z, out_flags, ex.z, ex.f);
          end
        end
      end
      if (in_valid && in_ready) begin
        acceptCount++;
        expQ.push_back(modelMul(in_prod, in_exp, in_sign, in_cls));
      end
      prevStall = out_valid && !out_ready;
      prevZ     = out_z;
      prevF     = out_flags;
    end
  end

  // Present one word and hold it until accepted; returns at accept edge + 1.
  task automatic applyStimulus(input logic [47:0] p, input logic [9:0] e,
                               input logic s, input logic [2:0] c);
    int waitCnt;
    waitCnt  = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_exp   = e;
    in_sign  = s;
    in_cls   = c;
    while (!in_ready && waitCnt < 20) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, want 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded) and check the literal result and latency.
  task automatic checkOutput(input string name, input logic [31:0] expZ, input logic [3:0] expF);
    int lat;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    compared++;
    if (out_valid !== 1'b1 || out_z !== expZ || out_flags !== expF || lat != Latency) begin
      mismatched++;
      $display("[TB] FAIL %s: got v=%b z=%h f=%b lat=%0d, want v=1 z=%h f=%b lat=%0d",
               name, out_valid, out_z, out_flags, lat, expZ, expF, Latency);
    end
  endtask

  // One directed vector: pin the model against the literal, then check the DUT.
  task automatic runVector(input string name, input logic [47:0] p, input logic [9:0] e,
                           input logic s, input logic [2:0] c,
                           input logic [31:0] expZ, input logic [3:0] expF);
    res_t m;
    m = modelMul(p, e, s, c);
    compared++;
    if (m.z !== expZ || m.f !== expF) begin
      mismatched++;
      $display("[TB] FAIL model_%s: got z=%h f=%b, want z=%h f=%b", name, m.z, m.f, expZ, expF);
    end
    out_ready = 1'b1;
    applyStimulus(p, e, s, c);
    checkOutput(name, expZ, expF);
  endtask

  // Stream the first n table entries, one attempt per cycle; reports cycles used.
  task automatic sendStream(input int n, output int cycles);
    int   idx;
    logic acc;
    idx    = 0;
    cycles = 0;
    while (idx < n && cycles < 100) begin
      in_valid = 1'b1;
      in_prod  = streamTab[idx].p;
      in_exp   = streamTab[idx].e;
      in_sign  = streamTab[idx].s;
      in_cls   = streamTab[idx].c;
      @(negedge clk);
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < n) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL stream_timeout: got %0d sent, want %0d", idx, n);
    end
  endtask

  // Let everything in flight drain, bounded.
  task automatic drain();
    int waitCnt;
    waitCnt   = 0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && waitCnt < 50) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc, acc0, del0;
    logic sawOut;

    streamTab[0] = '{p: 48'h4000_0000_0000, e: 10'd127, s: 1'b0, c: CLS_NORMAL};
    streamTab[1] = '{p: 48'h9000_0000_0000, e: 10'd127, s: 1'b1, c: CLS_NORMAL};
    streamTab[2] = '{p: 48'h4000_00C0_0000, e: 10'd127, s: 1'b0, c: CLS_NORMAL};
    streamTab[3] = '{p: 48'h4000_0060_0000, e: 10'd130, s: 1'b0, c: CLS_NORMAL};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_z !== 32'd0 || out_flags !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got v=%b z=%h f=%b, want v=0 z=0 f=0", out_valid, out_z, out_flags);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    runVector("one_x_one",   48'h4000_0000_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h3F80_0000, 4'b0000);
    runVector("onehalf_sq",  48'h9000_0000_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h4010_0000, 4'b0000);
    runVector("rne_tie_even",48'h4000_0040_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h3F80_0000, 4'b0001);
    runVector("rne_tie_odd", 48'h4000_00C0_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h3F80_0002, 4'b0001);
    runVector("overflow",    48'h8000_0000_0000, 10'd254,   1'b0, CLS_NORMAL,     32'h7F80_0000, 4'b0101);
    runVector("underflow",   48'h8000_0000_0000, -10'sd5,   1'b0, CLS_NORMAL,     32'h0000_0000, 4'b0011);
    runVector("above_half",  48'h4000_0060_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h3F80_0001, 4'b0001);
    runVector("carry_out",   48'h7FFF_FFC0_0000, 10'd127,   1'b0, CLS_NORMAL,     32'h4000_0000, 4'b0001);
    runVector("exp_zero_neg",48'h4000_0000_0000, 10'd0,     1'b1, CLS_NORMAL,     32'h8000_0000, 4'b0011);
    runVector("exp_one",     48'h4000_0000_0000, 10'd1,     1'b0, CLS_NORMAL,     32'h0080_0000, 4'b0000);
    runVector("max_normal",  48'h4000_0000_0000, 10'd254,   1'b0, CLS_NORMAL,     32'h7F00_0000, 4'b0000);
    runVector("exp_min",     48'h4000_0000_0000, -10'sd512, 1'b0, CLS_NORMAL,     32'h0000_0000, 4'b0011);
    runVector("exp_max",     48'h4000_0000_0000, 10'd511,   1'b1, CLS_NORMAL,     32'hFF80_0000, 4'b0101);
    runVector("neg_normal",  48'h9000_0000_0000, 10'd127,   1'b1, CLS_NORMAL,     32'hC010_0000, 4'b0000);
    runVector("nan",         48'h9000_0000_0000, 10'd127,   1'b1, CLS_NAN,        32'h7FC0_0000, 4'b0000);
    runVector("inf_x_zero",  48'h0000_0000_0000, 10'd127,   1'b0, CLS_INF_X_ZERO, 32'h7FC0_0000, 4'b1000);
    runVector("inf_neg",     48'h9000_0000_0000, 10'd3,     1'b1, CLS_INF,        32'hFF80_0000, 4'b0000);
    runVector("zero_neg",    48'h9000_0000_0000, 10'd127,   1'b1, CLS_ZERO,       32'h8000_0000, 4'b0000);
    drain();

    // Throughput: four back-to-back words with the output always ready.
    acc0 = acceptCount;
    sendStream(4, cyc);
    compared++;
    if (cyc != 4) begin
      mismatched++;
      $display("[TB] FAIL throughput: got %0d cycles, want 4", cyc);
    end
    drain();

    // Backpressure: output stalled while a four-word stream arrives.
    acc0      = acceptCount;
    del0      = deliverCount;
    out_ready = 1'b0;
    fork
      sendStream(4, cyc);
      begin
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL bp_stall: got in_ready=%b out_valid=%b, want 0 and 1", in_ready, out_valid);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    compared++;
    if (acceptCount - acc0 != 4 || deliverCount - del0 != 4) begin
      mismatched++;
      $display("[TB] FAIL bp_count: got %0d in %0d out, want 4 in 4 out",
               acceptCount - acc0, deliverCount - del0);
    end

    // Reset while a result is waiting at the output.
    out_ready = 1'b0;
    applyStimulus(48'h9000_0000_0000, 10'd127, 1'b0, CLS_NORMAL);
    for (int k = 1; k < Latency; k++) begin
      @(posedge clk);
      #1;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_pre: got out_valid=%b, want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_z !== 32'd0 || out_flags !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL rst_async: got v=%b z=%h f=%b, want v=0 z=0 f=0", out_valid, out_z, out_flags);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_release: got in_ready=%b out_valid=%b, want 1 and 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    sawOut    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawOut = 1'b1;
    end
    compared++;
    if (sawOut) begin
      mismatched++;
      $display("[TB] FAIL rst_stale: got out_valid=1 after release, want 0");
    end
    runVector("post_reset", 48'h4000_0000_0000, 10'd127, 1'b0, CLS_NORMAL, 32'h3F80_0000, 4'b0000);
    drain();

    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_empty: got %0d pending, want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sp_mult_norm_rnd.md
SP_MULT_NORM_RND -- requirements
Module: sp_mult_norm_rnd

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream product/exponent valid.
REQ-004 SHALL have port in_ready, output, 1, stage can accept on this edge.
REQ-005 SHALL have port in_prod, input, 48, unsigned 24x24 mantissa product from dadda_24b.
REQ-006 SHALL have port in_exp, input, 10, signed (two's complement) biased exponent ea+eb-127, pre-normalisation.
REQ-007 SHALL have port in_sign, input, 1, result sign sa^sb.
REQ-008 SHALL have port in_cls, input, 3, operand class {nan, inf_times_zero, inf_or_zero_sel}; encoding fixed in package.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts.
REQ-011 SHALL have port out_z, output, 32, IEEE-754 single result.
REQ-012 SHALL have port out_flags, output, 4, {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL transfer input only when in_valid && in_ready; output only when out_valid && out_ready.
REQ-014 SHALL drive in_ready = !stage_full || (out_valid && out_ready); same-edge accept and release permitted, no bubble.
REQ-015 SHALL hold out_z/out_flags stable while out_valid && !out_ready.
REQ-016 SHALL have latency 1 cycle (accept edge to out_valid) without FP_MULT_OUT_REG_EN; throughput 1/cycle.
REQ-017 SHALL normalise: prod[47]=1 -> mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp+1; else mant=prod[45:23], guard=prod[22], sticky=|prod[21:0].
REQ-018 SHALL round to nearest even: increment when guard && (sticky || mant[0]); inexact = guard || sticky.
REQ-019 SHALL on rounding carry-out set mant=0 and exp+1.
REQ-020 SHALL on final exp >= 255 output sign|0x7F800000, overflow=1, inexact=1.
REQ-021 SHALL on final exp <= 0 flush to signed zero, underflow=1, inexact=1 (no subnormal output).
REQ-022 SHALL on nan class output 0x7FC00000, flags 0; on inf_times_zero output 0x7FC00000, invalid=1.
REQ-023 SHALL on inf_or_zero_sel output signed inf (sel=1) or signed zero (sel=0), flags 0, ignoring in_prod.
REQ-024 SHALL compute exponent in 11-bit signed arithmetic; no wrap for in_exp in [-512,511].

Reset
REQ-025 SHALL on rst_n low clear all valid bits: out_valid=0, in_ready=1 after release, out_z=0, out_flags=0.
REQ-026 SHALL discard in-flight results on reset mid-operation; no output after release until a new accept.

Configuration
REQ-027 SHALL, when FP_MULT_OUT_REG_EN is defined, add a second handshaked register stage after rounding: latency 2, throughput 1/cycle, same ready rule per stage.
REQ-028 SHALL, without FP_MULT_OUT_REG_EN, register only once (latency 1); function identical otherwise.

Structure
REQ-029 SHALL place in package fp_sp_pkg: in_cls encoding, flag bit indices, constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, INF=32'h7F800000.
REQ-030 SHALL contain one sub-module fp_rne_round (combinational mant/guard/sticky -> rounded mant, carry, inexact).

Verification
REQ-031 SHALL check 1.0*1.0: in_prod=48'h4000_0000_0000, in_exp=127, sign 0 -> out_z=32'h3F800000, flags 4'b0000.
REQ-032 SHALL check 1.5*1.5: in_prod=48'h9000_0000_0000, in_exp=127 -> out_z=32'h40100000, flags 0.
REQ-033 SHALL check RNE: in_prod=48'h4000_0040_0000, exp 127 -> 32'h3F800000 inexact; in_prod=48'h4000_00C0_0000 -> 32'h3F800002 inexact.
REQ-034 SHALL check overflow: in_prod=48'h8000_0000_0000, in_exp=254 -> 32'h7F800000, flags 4'b0101; in_exp=-5 -> 32'h00000000, flags 4'b0011.
REQ-035 SHALL check backpressure: out_ready low 3 cycles with stream of 4 inputs -> in_ready low, out_z held, all 4 results delivered in order, none lost or duplicated.
REQ-036 SHALL check reset mid-stream: rst_n pulsed with out_valid=1 -> out_valid=0 immediately, no stale result after release; repeat all with FP_MULT_OUT_REG_EN defined (latency 2).
